// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: emits A/B/Z for a commanded move of N edges at a
// fixed edge period, tracking position modulo 4*PPR.
module quad_encoder_emulator #(
  parameter int PPR    = 334,
  parameter int PER_W  = 16,
  parameter int STEP_W = 32,
  localparam int POS_W = $clog2(4*PPR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              qa,
  output logic              qb,
  output logic              qz,
  output logic [POS_W-1:0]  pos,
  output logic              dir,
  output logic              busy,
  output logic              done
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(4*PPR-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] remaining;
  logic [PER_W-1:0]  per;
  logic [PER_W-1:0]  timer;
  logic              accept;
  logic              edge_now;
  logic              last_edge;
  logic [POS_W-1:0]  pos_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // abort outranks an edge falling due in the same cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    edge_now  = 1'b0;
    last_edge = 1'b0;
    case (state)
      IDLE: begin
        accept = cmd_valid;
        if (cmd_valid && cmd_steps != '0) state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (timer == per - PER_W'(1)) begin
          edge_now = 1'b1;
          if (remaining == STEP_W'(1)) begin
            last_edge = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (dir) pos_nxt = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
    else     pos_nxt = (pos == '0) ? POS_MAX : pos - POS_W'(1);
  end

  // CW walks {qb,qa} 00->01->11->10; CCW walks it backwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa        <= 1'b0;
      qb        <= 1'b0;
      qz        <= 1'b1;
      pos       <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      remaining <= '0;
      per       <= PER_W'(1);
      timer     <= '0;
    end else begin
      done      <= 1'b0;
      busy      <= (state_nxt == RUN);
      cmd_ready <= (state_nxt == IDLE);
      if (accept) begin
        dir       <= cmd_dir;
        remaining <= cmd_steps;
        per       <= (cmd_period == '0) ? PER_W'(1) : cmd_period;
        timer     <= '0;
        if (cmd_steps == '0) done <= 1'b1;
      end
      if (state == RUN) begin
        timer <= timer + PER_W'(1);
        if (edge_now) begin
          timer     <= '0;
          remaining <= remaining - STEP_W'(1);
          pos       <= pos_nxt;
          qz        <= (pos_nxt == '0);
          done      <= last_edge;
          if (dir) begin
            qa <= ~qb;
            qb <= qa;
          end else begin
            qa <= qb;
            qb <= ~qa;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: scoreboard of expected edges plus a
// loopback quadrature decoder watching qa/qb.
module tb_quad_encoder_emulator;

  localparam int NPOS = 1336;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [31:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        qa, qb, qz;
  logic [10:0] pos;
  logic        dir, busy, done;

  quad_encoder_emulator dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .qa(qa), .qb(qb), .qz(qz), .pos(pos), .dir(dir),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic [10:0] pos;
    logic       qz;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_count = 0;
  logic [1:0] prev_ph = 2'b00;
  int         dec_pos = 0;
  int         mon_pi, mon_ci;
  int         m_pos = 0;
  int         m_idx = 0;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int phIdx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Loopback decoder and scoreboard consumer: one pop per observed phase change
  always @(negedge clk) begin
    if (rst) begin
      prev_ph = 2'b00;
      dec_pos = 0;
    end else begin
      if (done) done_count++;
      if ({qb, qa} !== prev_ph) begin
        mon_pi = phIdx(prev_ph);
        mon_ci = phIdx({qb, qa});
        if (mon_ci == (mon_pi + 1) % 4)      dec_pos = (dec_pos + 1) % NPOS;
        else if (mon_ci == (mon_pi + 3) % 4) dec_pos = (dec_pos + NPOS - 1) % NPOS;
        checkOutput("single_bit_change", $countones(prev_ph ^ {qb, qa}), 1);
        checkOutput("decoder_pos", 32'(pos), dec_pos);
        checkOutput("edge_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          checkOutput("edge_cycle", cyc, mon_e.cyc);
          checkOutput("edge_phase", 32'({qb, qa}), 32'(mon_e.ph));
          checkOutput("edge_pos", 32'(pos), 32'(mon_e.pos));
          checkOutput("edge_qz", 32'(qz), 32'(mon_e.qz));
        end
        prev_ph = {qb, qa};
      end
    end
  end

  task automatic applyStimulus(input logic d, input int steps, input int period,
                               input int n_edges, output int acc_cyc);
    int   per_eff;
    exp_t e;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = steps;
    cmd_period = period[15:0];
    acc_cyc    = cyc + 1;
    per_eff    = (period == 0) ? 1 : period;
    for (int i = 1; i <= n_edges; i++) begin
      m_idx = d ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
      m_pos = d ? (m_pos + 1) % NPOS : (m_pos + NPOS - 1) % NPOS;
      e.cyc = acc_cyc + i * per_eff;
      e.ph  = gray[m_idx];
      e.pos = m_pos[10:0];
      e.qz  = (m_pos == 0);
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_dir    = ~d;
    cmd_steps  = $urandom;
    cmd_period = 16'($urandom);
  endtask

  task automatic waitDone(input int exp_cyc, input string tag);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checkOutput({tag, "_done_cycle"}, cyc, exp_cyc);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 1);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_sb_drained"}, sb.size(), 0);
    checkOutput({tag, "_pos"}, 32'(pos), m_pos);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int a;
    int dc;
    int guard;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_qa", 32'(qa), 0);
    checkOutput("rst_qb", 32'(qb), 0);
    checkOutput("rst_pos", 32'(pos), 0);
    checkOutput("rst_qz", 32'(qz), 1);
    checkOutput("rst_dir", 32'(dir), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);

    $display("[TB] CW 8 edges, period 4");
    applyStimulus(1'b1, 8, 4, 8, a);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_ready_low", 32'(cmd_ready), 0);
    checkOutput("t1_dir", 32'(dir), 1);
    waitDone(a + 32, "t1");

    $display("[TB] CCW back to 0, then CCW 3 edges, period 1 across wrap");
    applyStimulus(1'b0, 8, 1, 8, a);
    waitDone(a + 8, "t2a");
    applyStimulus(1'b0, 3, 1, 3, a);
    waitDone(a + 3, "t2b");

    $display("[TB] CW full revolution, period 2");
    applyStimulus(1'b1, 3, 1, 3, a);
    waitDone(a + 3, "t3a");
    applyStimulus(1'b1, NPOS, 2, NPOS, a);
    waitDone(a + 2 * NPOS, "t3b");
    checkOutput("t3_qz_end", 32'(qz), 1);

    $display("[TB] Abort on the 6th edge cycle of a 10-edge move");
    dc = done_count;
    applyStimulus(1'b1, 10, 3, 5, a);
    guard = 0;
    while (cyc < a + 17 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t5_pos", 32'(pos), m_pos);
    checkOutput("t5_phase_hold", 32'({qb, qa}), 32'(gray[m_idx]));
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_ready", 32'(cmd_ready), 1);
    checkOutput("t5_no_done", done_count, dc);
    checkOutput("t5_sb_drained", sb.size(), 0);
    applyStimulus(1'b0, 5, 2, 5, a);
    waitDone(a + 10, "t5b");
    checkOutput("t5_home_qz", 32'(qz), 1);

    $display("[TB] Zero-step command and period 0");
    applyStimulus(1'b1, 0, 5, 0, a);
    waitDone(a, "t4a");
    applyStimulus(1'b1, 2, 0, 2, a);
    waitDone(a + 2, "t4b");

    $display("[TB] Command while busy, then reset mid-move");
    applyStimulus(1'b1, 20, 2, 3, a);
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b0;
    cmd_steps  = 32'd1;
    cmd_period = 16'd1;
    #1;
    checkOutput("t6_ready_busy", 32'(cmd_ready), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (cyc < a + 7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t6_sb_drained", sb.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_qa", 32'(qa), 0);
    checkOutput("t6_rst_qb", 32'(qb), 0);
    checkOutput("t6_rst_pos", 32'(pos), 0);
    checkOutput("t6_rst_qz", 32'(qz), 1);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_ready", 32'(cmd_ready), 1);
    sb.delete();
    m_pos = 0;
    m_idx = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2, 1, 2, a);
    waitDone(a + 2, "t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
